fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the shared instruction/data memory.
- Owns the PC and drives instruction_memory_a / instruction_memory_en. Samples the returned instruction_memory_v and buffers words in a small FIFO for decode, which reads them over a valid/ready handshake.
- Handles branch redirects and halts on the all-ones pause word.

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response plus the
// valid/ready channel toward decode. master = fetch unit, slave = memory/decode.
interface fetch_unit_if;
  logic        instruction_memory_en;
  logic [31:0] instruction_memory_a;
  logic [31:0] instruction_memory_v;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;

  modport master (
    output instruction_memory_en, instruction_memory_a,
    input  instruction_memory_v,
    output instr_valid, instr_word, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instruction_memory_en, instruction_memory_a,
    output instruction_memory_v,
    input  instr_valid, instr_word, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word per cycle into a small
// FIFO for decode, handles redirects and halts. Optional macro: FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned DEPTH     = 2,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        fetch_en,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_stall_count,
`endif
  fetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [1:0]  state, state_nxt;
  logic [31:0] pc_p0;
  logic [31:0] word_p1 [DEPTH];
  logic [31:0] pc_p1   [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [AW:0] occupancy;
  logic        fifo_full, fifo_empty;
  logic        pop, issue, halt_hit, push;

  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_full  = (occupancy == FULL_CNT);
  assign fifo_empty = (wr_ptr == rd_ptr);

  // A redirect cancels the same-cycle pop along with the flush.
  assign pop      = !fifo_empty && bus.instr_ready && !branch_taken;
  assign issue    = (state == FETCH) && fetch_en && !branch_taken && (!fifo_full || pop);
  assign halt_hit = issue && (bus.instruction_memory_v == HALT_WORD);
  assign push     = issue && !halt_hit;

  assign bus.instruction_memory_a  = pc_p0;
  assign bus.instruction_memory_en = (state == FETCH) && fetch_en;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_en && !branch_taken) state_nxt = FETCH;
      FETCH: begin
        if (!fetch_en)     state_nxt = IDLE;
        else if (halt_hit) state_nxt = HALTED;
      end
      HALTED:  if (branch_taken) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: PC, FSM and FIFO pointers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      pc_p0  <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (branch_taken) begin
        pc_p0  <= word_align(branch_target);
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          pc_p0  <= pc_p0 + 32'd4;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Stage p1: captured words; storage is unreset, outputs are gated by emptiness
  always_ff @(posedge Clk) begin
    if (push) begin
      word_p1[wr_ptr[AW-1:0]] <= bus.instruction_memory_v;
      pc_p1[wr_ptr[AW-1:0]]   <= pc_p0;
    end
  end

  assign bus.instr_valid = !fifo_empty;
  assign bus.instr_word  = fifo_empty ? 32'd0 : word_p1[rd_ptr[AW-1:0]];
  assign bus.instr_pc    = fifo_empty ? 32'd0 : pc_p1[rd_ptr[AW-1:0]];

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_fetch_count <= '0;
      perf_stall_count <= '0;
    end else begin
      if (push) perf_fetch_count <= perf_fetch_count + 32'd1;
      if ((state == FETCH) && fetch_en && fifo_full && !pop)
        perf_stall_count <= perf_stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle-vector table for streaming/backpressure/halt,
// plus hand-written redirect, reset and PC-wrap sequences.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        fetch_en;
  logic        branch_taken;
  logic [31:0] branch_target;
  fetch_unit_if bus ();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_count, perf_stall_count;
`endif

  always #5 Clk = ~Clk;

  fetch_unit dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .fetch_en      (fetch_en),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetch_count (perf_fetch_count),
    .perf_stall_count (perf_stall_count),
`endif
    .bus           (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h1111_1111;
      32'h4:   return 32'h2222_2222;
      32'h8:   return 32'h3333_3333;
      32'hC:   return 32'h4444_4444;
      32'h10:  return 32'hFFFF_FFFF;
      default: return {8'hA5, a[23:0]};
    endcase
  endfunction

  assign bus.instruction_memory_v = mem_word(bus.instruction_memory_a);

  typedef struct {
    logic        rst, fe, bt, rdy, chk;
    logic [31:0] tgt;
    logic        ev, een;
    logic [31:0] ea, epc, ew, epf, eps;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input logic rst, fe, bt, input logic [31:0] tgt, input logic rdy,
                     input logic chk, ev, een, input logic [31:0] ea, epc, ew, epf, eps);
    vec_t v;
    v.rst = rst; v.fe = fe; v.bt = bt; v.tgt = tgt; v.rdy = rdy; v.chk = chk;
    v.ev = ev; v.een = een; v.ea = ea; v.epc = epc; v.ew = ew; v.epf = epf; v.eps = eps;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic rst, fe, bt, input logic [31:0] tgt, input logic rdy);
    @(negedge Clk);
    Rst = rst; fetch_en = fe; branch_taken = bt; branch_target = tgt; bus.instr_ready = rdy;
    #1;
  endtask

  initial begin
    Rst = 1'b1; fetch_en = 1'b0; branch_taken = 1'b0; branch_target = '0; bus.instr_ready = 1'b0;

    // rst fe bt tgt rdy | chk ev een a pc word pf ps
    add(1,0,0,0,0, 0, 0,0,0,0,0,0,0);
    add(1,0,0,0,0, 0, 0,0,0,0,0,0,0);
    add(0,0,0,0,0, 1, 0,0,32'h0,32'h0,32'h0,0,0);
    // streaming with decode always ready
    add(0,1,0,0,1, 1, 0,0,32'h0,32'h0,32'h0,0,0);
    add(0,1,0,0,1, 1, 0,1,32'h0,32'h0,32'h0,0,0);
    add(0,1,0,0,1, 1, 1,1,32'h4,32'h0,32'h1111_1111,1,0);
    add(0,1,0,0,1, 1, 1,1,32'h8,32'h4,32'h2222_2222,2,0);
    add(0,1,0,0,1, 1, 1,1,32'hC,32'h8,32'h3333_3333,3,0);
    add(1,1,0,0,1, 0, 0,0,0,0,0,0,0);
    // backpressure six cycles, then drain into the halt word at 0x10
    add(0,1,0,0,0, 1, 0,0,32'h0,32'h0,32'h0,0,0);
    add(0,1,0,0,0, 1, 0,1,32'h0,32'h0,32'h0,0,0);
    add(0,1,0,0,0, 1, 1,1,32'h4,32'h0,32'h1111_1111,1,0);
    add(0,1,0,0,0, 1, 1,1,32'h8,32'h0,32'h1111_1111,2,0);
    add(0,1,0,0,0, 1, 1,1,32'h8,32'h0,32'h1111_1111,2,1);
    add(0,1,0,0,0, 1, 1,1,32'h8,32'h0,32'h1111_1111,2,2);
    add(0,1,0,0,1, 1, 1,1,32'h8,32'h0,32'h1111_1111,2,3);
    add(0,1,0,0,1, 1, 1,1,32'hC,32'h4,32'h2222_2222,3,3);
    add(0,1,0,0,1, 1, 1,1,32'h10,32'h8,32'h3333_3333,4,3);
    add(0,1,0,0,1, 1, 1,0,32'h10,32'hC,32'h4444_4444,4,3);
    add(0,1,0,0,1, 1, 0,0,32'h10,32'h0,32'h0,4,3);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].fe, tbl[i].bt, tbl[i].tgt, tbl[i].rdy);
      if (tbl[i].chk) begin
        check($sformatf("row%0d valid", i), {31'd0, bus.instr_valid}, {31'd0, tbl[i].ev});
        check($sformatf("row%0d mem_en", i), {31'd0, bus.instruction_memory_en}, {31'd0, tbl[i].een});
        check($sformatf("row%0d mem_a", i), bus.instruction_memory_a, tbl[i].ea);
        check($sformatf("row%0d instr_pc", i), bus.instr_pc, tbl[i].epc);
        check($sformatf("row%0d instr_word", i), bus.instr_word, tbl[i].ew);
`ifdef FETCH_PERF_CNT_EN
        check($sformatf("row%0d perf_fetch", i), perf_fetch_count, tbl[i].epf);
        check($sformatf("row%0d perf_stall", i), perf_stall_count, tbl[i].eps);
`endif
      end
    end

    // resume from HALTED via redirect to 0x0, then fill the FIFO
    step(0,1,1,32'h0,0);
    check("halt_branch mem_en", {31'd0, bus.instruction_memory_en}, 32'd0);
    step(0,1,0,0,0);
    check("resume mem_en", {31'd0, bus.instruction_memory_en}, 32'd1);
    check("resume mem_a", bus.instruction_memory_a, 32'h0);
    check("resume valid", {31'd0, bus.instr_valid}, 32'd0);
    step(0,1,0,0,0);
    check("resume head_pc", bus.instr_pc, 32'h0);
    check("resume head_word", bus.instr_word, 32'h1111_1111);
    step(0,1,0,0,0);
    check("full mem_a", bus.instruction_memory_a, 32'h8);
    check("full head_pc", bus.instr_pc, 32'h0);

    // redirect while full, unaligned target, same-cycle ready ignored
    step(0,1,1,32'h103,1);
    step(0,1,0,0,0);
    check("redir valid", {31'd0, bus.instr_valid}, 32'd0);
    check("redir mem_a", bus.instruction_memory_a, 32'h100);
    check("redir mem_en", {31'd0, bus.instruction_memory_en}, 32'd1);
    step(0,1,0,0,0);
    check("redir head_pc", bus.instr_pc, 32'h100);
    check("redir head_word", bus.instr_word, 32'hA500_0100);

    // reset mid-stream with pc=0x20
    step(0,1,1,32'h1C,0);
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    check("pre_rst valid", {31'd0, bus.instr_valid}, 32'd1);
    check("pre_rst mem_a", bus.instruction_memory_a, 32'h20);
    step(1,1,0,0,0);
    step(0,1,0,0,0);
    check("post_rst valid", {31'd0, bus.instr_valid}, 32'd0);
    check("post_rst mem_a", bus.instruction_memory_a, 32'h0);
    check("post_rst mem_en", {31'd0, bus.instruction_memory_en}, 32'd0);
    check("post_rst word", bus.instr_word, 32'h0);
    check("post_rst pc", bus.instr_pc, 32'h0);

    // redirect in IDLE to the top word, then PC wrap and FETCH->IDLE
    step(1,0,0,0,0);
    step(0,0,1,32'hFFFF_FFFE,0);
    step(0,1,0,0,0);
    check("idle_br mem_a", bus.instruction_memory_a, 32'hFFFF_FFFC);
    check("idle_br mem_en", {31'd0, bus.instruction_memory_en}, 32'd0);
    step(0,1,0,0,0);
    check("top mem_en", {31'd0, bus.instruction_memory_en}, 32'd1);
    step(0,1,0,0,1);
    check("wrap mem_a", bus.instruction_memory_a, 32'h0);
    check("wrap head_pc", bus.instr_pc, 32'hFFFF_FFFC);
    check("wrap head_word", bus.instr_word, 32'hA5FF_FFFC);
    step(0,0,0,0,1);
    check("fe_off mem_en", {31'd0, bus.instruction_memory_en}, 32'd0);
    check("fe_off head_pc", bus.instr_pc, 32'h0);
    step(0,0,0,0,1);
    check("idle valid", {31'd0, bus.instr_valid}, 32'd0);
    check("idle pc_hold", bus.instruction_memory_a, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
